// File: rtl/i2c_slave_standard.sv
// I2C target (slave).
// SCL and SDA are oversampled on clk, and the block detects START, STOP and repeated START.
// It matches a programmable 7-bit address, receives bytes into RX_DATA and transmits TX_DATA.
// Software reaches it through the wr_en/r_en/addr_offset register bus.
module i2c_slave_standard #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        r_en,
    input  logic [7:0]  addr_offset,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq,
    input  logic        scl,
    inout  wire         sda
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_OWN    = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_RX     = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       ack_q, ack_d;
    logic       sda_low_q, sda_low_d;
    logic       en_q, en_d;
    logic [6:0] own_addr_q, own_addr_d;
    logic [7:0] tx_data_q, tx_data_d, rx_data_q, rx_data_d;
    logic       busy_q, busy_d, rx_valid_q, rx_valid_d, rx_overflow_q, rx_overflow_d;
    logic       stop_seen_q, stop_seen_d, rw_dir_q, rw_dir_d, master_nack_q, master_nack_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;
    logic       wr_status, rd_rx, rx_free;
    logic       unused_data_bits;

    // Open drain: the pin is only ever pulled low or released.
    assign sda = sda_low_q ? 1'b0 : 1'bz;
    assign irq = rx_valid_q | rx_overflow_q | stop_seen_q;
    assign unused_data_bits = ^data_in[31:8];

    // Synchronized pin values and bus events, all taken from the last sync stage and its history flop.
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign byte_in   = {shift_q[6:0], sda_s};

    assign wr_status = wr_en && (addr_offset == OFF_STATUS);
    assign rd_rx     = r_en && (addr_offset == OFF_RX);
    // A RX_DATA read in the same clk frees the buffer before a new byte lands.
    assign rx_free   = !(rx_valid_q && !rd_rx);

    // Shift the pins through the synchronizers and keep one sample of history.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
    end

    // Register bus updates, followed by the protocol FSM. Hardware sets come last, so they win over W1C.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ack_d         = ack_q;
        sda_low_d     = sda_low_q;
        en_d          = (wr_en && addr_offset == OFF_CTRL) ? data_in[0]   : en_q;
        own_addr_d    = (wr_en && addr_offset == OFF_OWN)  ? data_in[6:0] : own_addr_q;
        tx_data_d     = (wr_en && addr_offset == OFF_TX)   ? data_in[7:0] : tx_data_q;
        rx_data_d     = rx_data_q;
        busy_d        = busy_q;
        rw_dir_d      = rw_dir_q;
        rx_valid_d    = rx_valid_q & ~rd_rx;
        rx_overflow_d = rx_overflow_q & ~(wr_status & data_in[2]);
        stop_seen_d   = stop_seen_q   & ~(wr_status & data_in[3]);
        master_nack_d = master_nack_q & ~(wr_status & data_in[5]);

        if (!en_d) begin
            state_d   = S_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            sda_low_d   = 1'b0;
            stop_seen_d = 1'b1;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (byte_in[7:1] == own_addr_q) begin
                            state_d  = S_ADDR_ACK;
                            ack_d    = 1'b1;
                            rw_dir_d = byte_in[0];
                            busy_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                // The first fall opens the ACK slot (bit_cnt still 8). The second fall closes it.
                S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_low_d = ack_q;
                        bit_cnt_d = '0;
                    end else if (state_q == S_ADDR_ACK && rw_dir_q) begin
                        state_d   = S_TX_BYTE;
                        shift_d   = tx_data_q;
                        sda_low_d = ~tx_data_q[7];
                    end else begin
                        state_d   = S_RX_BYTE;
                        sda_low_d = 1'b0;
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_RX_ACK;
                        ack_d   = rx_free;
                        if (rx_free) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_overflow_d = 1'b1;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = S_TX_ACK;
                            sda_low_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                // Any fall seen here comes after an ACKed slot, so the next byte is loaded.
                S_TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        master_nack_d = 1'b1;
                        state_d       = S_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d   = S_TX_BYTE;
                        bit_cnt_d = '0;
                        shift_d   = tx_data_q;
                        sda_low_d = ~tx_data_q[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // State and register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '0;  sda_sync_q <= '0;  scl_hist_q <= 1'b0;  sda_hist_q <= 1'b0;
            state_q    <= S_IDLE;  bit_cnt_q <= '0;  shift_q <= '0;  ack_q <= 1'b0;
            sda_low_q  <= 1'b0;  en_q <= 1'b0;  own_addr_q <= '0;  tx_data_q <= '0;
            rx_data_q  <= '0;  busy_q <= 1'b0;  rx_valid_q <= 1'b0;  rx_overflow_q <= 1'b0;
            stop_seen_q <= 1'b0;  rw_dir_q <= 1'b0;  master_nack_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values, just like hardware does.
            scl_sync_q <= scl_sync_d;  sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;  sda_hist_q <= sda_hist_d;
            state_q    <= state_d;  bit_cnt_q <= bit_cnt_d;  shift_q <= shift_d;  ack_q <= ack_d;
            sda_low_q  <= sda_low_d;  en_q <= en_d;  own_addr_q <= own_addr_d;  tx_data_q <= tx_data_d;
            rx_data_q  <= rx_data_d;  busy_q <= busy_d;  rx_valid_q <= rx_valid_d;
            rx_overflow_q <= rx_overflow_d;  stop_seen_q <= stop_seen_d;  rw_dir_q <= rw_dir_d;
            master_nack_q <= master_nack_d;
        end
    end

    // Read mux. It returns 0 when r_en is low and for unmapped offsets.
    always_comb begin
        data_out = '0;
        if (r_en) begin
            case (addr_offset)
                OFF_CTRL:   data_out = {31'd0, en_q};
                OFF_OWN:    data_out = {25'd0, own_addr_q};
                OFF_TX:     data_out = {24'd0, tx_data_q};
                OFF_RX:     data_out = {24'd0, rx_data_q};
                OFF_STATUS: data_out = {26'd0, master_nack_q, rw_dir_q, stop_seen_q,
                                        rx_overflow_q, rx_valid_q, busy_q};
                default:    data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_standard.sv
// Self-checking bench for i2c_slave_standard.
// A bit-banged I2C master drives the DUT, and a transaction-level model predicts ACKs, data and STATUS.
module tb_i2c_slave_standard;

    localparam int Q = 8;  // clks per quarter SCL period
    localparam logic [7:0] OFF_CTRL = 8'h00, OFF_OWN = 8'h04, OFF_TX = 8'h08,
                           OFF_RX = 8'h0C, OFF_STATUS = 8'h10;

    logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, r_en = 1'b0;
    logic [7:0]  addr_offset = '0;
    logic [31:0] data_in = '0, data_out;
    logic        irq, scl = 1'b1, m_sda_low = 1'b0;
    wire         sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_standard #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .r_en(r_en), .addr_offset(addr_offset),
        .data_in(data_in), .data_out(data_out), .irq(irq), .scl(scl), .sda(sda)
    );

    int checks = 0, failures = 0;
    int slave_low_cnt = 0;

    // Reference model state, kept at the level of whole transactions.
    logic       m_en, m_match, m_busy, m_rx_valid, m_ovf, m_stop, m_rw, m_nack;
    logic [6:0] m_own;
    logic [7:0] m_tx, m_rx;

    // Count clks where SDA is low even though the master is not pulling it.
    always @(negedge clk) if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_en = 0; m_match = 0; m_busy = 0; m_rx_valid = 0; m_ovf = 0; m_stop = 0;
        m_rw = 0; m_nack = 0; m_own = '0; m_tx = '0; m_rx = '0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- register bus ----------------
    task automatic reg_write(input logic [7:0] off, input logic [31:0] d);
        @(negedge clk); wr_en = 1'b1; addr_offset = off; data_in = d;
        @(negedge clk); wr_en = 1'b0; data_in = '0;
    endtask

    task automatic reg_read(input logic [7:0] off, output logic [31:0] d);
        @(negedge clk); r_en = 1'b1; addr_offset = off;
        #1 d = data_out;
        @(negedge clk); r_en = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] off, input logic [31:0] d);
        reg_write(off, d);
        case (off)
            OFF_CTRL:   begin m_en = d[0]; if (!d[0]) m_busy = 0; end
            OFF_OWN:    m_own = d[6:0];
            OFF_TX:     m_tx = d[7:0];
            OFF_STATUS: begin if (d[2]) m_ovf = 0; if (d[3]) m_stop = 0; if (d[5]) m_nack = 0; end
            default: ;
        endcase
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        reg_read(OFF_STATUS, d);
        check({tag, "_status"}, d, {26'd0, m_nack, m_rw, m_stop, m_ovf, m_rx_valid, m_busy});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_rx_valid | m_ovf | m_stop});
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d;
        reg_read(OFF_RX, d);
        check(tag, d, {24'd0, m_rx});
        m_rx_valid = 0;
    endtask

    // ---------------- bit-level master ----------------
    // Works from idle (SCL high) and as a repeated START (SCL low).
    task automatic bus_start();
        m_sda_low = 1'b0; wait_clks(Q); scl = 1'b1; wait_clks(Q);
        m_sda_low = 1'b1; wait_clks(Q); scl = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_clks(Q); scl = 1'b1; wait_clks(Q);
        m_sda_low = 1'b0; wait_clks(Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda_low = !b; wait_clks(Q); scl = 1'b1; wait_clks(Q);
        s = sda; wait_clks(Q); scl = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin send_bit(1'b1, s); d[i] = s; end
        send_bit(!give_ack, s);
    endtask

    // ---------------- transaction level: master plus model ----------------
    task automatic xfer_addr(input logic [6:0] a, input logic rw, input string tag);
        logic acked;
        bus_start();
        m_match = m_en && (a == m_own);
        if (m_match) begin m_busy = 1; m_rw = rw; end
        write_byte({a, rw}, acked);
        check(tag, {31'd0, acked}, {31'd0, m_match});
    endtask

    task automatic xfer_wr(input logic [7:0] b, input string tag);
        logic acked, exp;
        exp = 0;
        if (m_match) begin
            if (m_rx_valid) m_ovf = 1;
            else begin m_rx = b; m_rx_valid = 1; exp = 1; end
        end
        write_byte(b, acked);
        check(tag, {31'd0, acked}, {31'd0, exp});
    endtask

    task automatic xfer_rd(input logic give_ack, input string tag);
        logic [7:0] d, exp;
        exp = m_match ? m_tx : 8'hFF;
        read_byte(give_ack, d);
        if (m_match && !give_ack) m_nack = 1;
        check(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic xfer_stop();
        bus_stop();
        if (m_en) begin m_stop = 1; m_busy = 0; end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  tmp;
        int          low_before;
        mdl_reset();

        // ---- reset state ----
        wait_clks(4);
        check("rst_sda_released", {31'd0, sda}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        wait_clks(2);
        check("dout_no_ren", data_out, 32'd0);
        reg_read(OFF_CTRL, d);  check("rst_ctrl", d, 32'd0);
        reg_read(OFF_OWN, d);   check("rst_own", d, 32'd0);
        check_status("rst");

        // ---- configuration, readback, unmapped offset ----
        cfg_write(OFF_CTRL, 32'h1);
        cfg_write(OFF_OWN, 32'h50);
        reg_write(8'h14, 32'hFFFF_FFFF);
        reg_read(8'h14, d);     check("unmapped_read", d, 32'd0);
        reg_read(OFF_OWN, d);   check("own_readback", d, 32'h50);
        reg_read(OFF_CTRL, d);  check("ctrl_readback", d, 32'h1);

        // ---- 1: write 0xA5 ----
        xfer_addr(7'h50, 1'b0, "t1_addr_ack");
        check_status("t1_mid");
        xfer_wr(8'hA5, "t1_data_ack");
        xfer_stop();
        check_status("t1_end");
        check_rx("t1_rx");
        check_status("t1_rx_cleared");
        cfg_write(OFF_STATUS, 32'h2C);
        check_status("t1_w1c");

        // ---- 2: read 0x3C, NACK ----
        cfg_write(OFF_TX, 32'h3C);
        xfer_addr(7'h50, 1'b1, "t2_addr_ack");
        xfer_rd(1'b0, "t2_data");
        xfer_stop();
        check_status("t2_end");
        cfg_write(OFF_STATUS, 32'h2C);

        // ---- 3: address mismatch ----
        low_before = slave_low_cnt;
        xfer_addr(7'h51, 1'b0, "t3_addr_nack");
        xfer_wr(8'h5A, "t3_data_nack");
        check_status("t3_mid");
        xfer_stop();
        check("t3_never_driven", slave_low_cnt - low_before, 32'd0);
        check_rx("t3_rx_unchanged");
        cfg_write(OFF_STATUS, 32'h2C);

        // ---- 4: overflow ----
        xfer_addr(7'h50, 1'b0, "t4_addr_ack");
        xfer_wr(8'h11, "t4_first_ack");
        xfer_wr(8'h22, "t4_second_nack");
        xfer_stop();
        check_status("t4_end");
        check_rx("t4_rx_first");
        cfg_write(OFF_STATUS, 32'h2C);

        // ---- 5: repeated START into a read, TX_DATA written mid-byte ----
        cfg_write(OFF_TX, 32'h00 | ($urandom & 32'hFF));
        xfer_addr(7'h50, 1'b0, "t5_addr_w");
        xfer_wr(8'h77, "t5_data_ack");
        xfer_addr(7'h50, 1'b1, "t5_addr_r");
        check_status("t5_mid");
        tmp = 8'($urandom);
        fork
            xfer_rd(1'b1, "t5_byte0");
            begin wait_clks(10 * Q); cfg_write(OFF_TX, {24'd0, tmp}); end
        join
        xfer_rd(1'b0, "t5_byte1_new_tx");
        xfer_stop();
        check_status("t5_end");
        check_rx("t5_rx");
        cfg_write(OFF_STATUS, 32'h2C);

        // ---- 6a: enable cleared while the target drives SDA low ----
        cfg_write(OFF_TX, 32'h00);
        xfer_addr(7'h50, 1'b1, "t6a_addr");
        fork
            read_byte(1'b0, tmp);
            begin
                wait_clks(Q + Q / 2);
                check("t6a_driving", {31'd0, sda}, 32'd0);
                cfg_write(OFF_CTRL, 32'h0);
                check("t6a_released", {31'd0, sda}, 32'd1);
            end
        join
        bus_stop();
        check_status("t6a_end");

        // ---- 6b: async reset while the target drives SDA low ----
        cfg_write(OFF_CTRL, 32'h1);
        xfer_addr(7'h50, 1'b1, "t6b_addr");
        fork
            read_byte(1'b0, tmp);
            begin
                wait_clks(Q + Q / 2);
                check("t6b_driving", {31'd0, sda}, 32'd0);
                #2 rst_n = 1'b0;
                #1 check("t6b_released", {31'd0, sda}, 32'd1);
                mdl_reset();
                wait_clks(2);
                rst_n = 1'b1;
            end
        join
        bus_stop();
        check_status("t6b_end");
        reg_read(OFF_CTRL, d);  check("t6b_ctrl", d, 32'd0);

        // ---- randomized transactions ----
        cfg_write(OFF_CTRL, 32'h1);
        cfg_write(OFF_OWN, {25'd0, 7'($urandom)});
        for (int it = 0; it < 6; it++) begin
            logic [6:0] a;
            logic       rw;
            int         nb;
            a  = ($urandom_range(0, 3) == 0) ? (m_own ^ 7'($urandom_range(1, 127))) : m_own;
            rw = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            if (rw) cfg_write(OFF_TX, $urandom & 32'hFF);
            if ($urandom_range(0, 1) == 1) check_rx("rnd_rx_pre");
            xfer_addr(a, rw, "rnd_addr");
            for (int k = 0; k < nb; k++) begin
                if (rw) xfer_rd(k != nb - 1, "rnd_rd");
                else    xfer_wr(8'($urandom), "rnd_wr");
            end
            xfer_stop();
            check_status("rnd_end");
            cfg_write(OFF_STATUS, 32'h2C);
        end
        check_rx("rnd_rx_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
